// File: rtl/mem_arb_pkg.sv
// Shared types for the dual-port RAM arbiter: read-tag record, statistics counter width
// and a saturating add used by the optional counters.
package mem_arb_pkg;

    localparam int CNT_W     = 32;
    // Wide enough for any practical requester count (up to 256).
    localparam int TAG_IDX_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] value,
                                                input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, value} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set bit of mask, searching
// upward from ptr and wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IW-1:0]      ptr,
    output logic               found,
    output logic [IW-1:0]      idx
);

    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && mask[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_dual_arb.sv
// Round-robin scheduler granting up to two accesses per cycle onto a dual-port RAM.
// Define MEM_DUAL_ARB_STATS_EN to add the grant_cnt/skip_cnt statistics outputs.
module mem_dual_arb
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    parameter  int DEPTH   = 64,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         wren,
    input  logic [NUM_REQ*AW-1:0]      addr,
    input  logic [NUM_REQ*WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rvalid,
    output logic [NUM_REQ*WIDTH-1:0]   rdata,
    output logic [AW-1:0]              mem_address_0,
    output logic [AW-1:0]              mem_address_1,
    output logic [WIDTH-1:0]           mem_data_0,
    output logic [WIDTH-1:0]           mem_data_1,
    output logic                       mem_wren_0,
    output logic                       mem_wren_1,
    input  logic [WIDTH-1:0]           mem_q_0,
    input  logic [WIDTH-1:0]           mem_q_1
`ifdef MEM_DUAL_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]           grant_cnt,
    output logic [CNT_W-1:0]           skip_cnt
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]      ptr_q, ptr_d;
    tag_t               tag0_q, tag0_d, tag1_q, tag1_d;
    logic               foundA, foundB, skipFound;
    logic [IW-1:0]      idxA, idxB, skipIdx;
    logic [NUM_REQ-1:0] conflict, maskB;

    rr_pick #(.NUM_REQ(NUM_REQ)) pickA (
        .mask  (req),
        .ptr   (ptr_q),
        .found (foundA),
        .idx   (idxA)
    );

    // Port 1 candidates: everyone still requesting except A and anyone clashing with A's address.
    always_comb begin
        conflict = '0;
        maskB    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            conflict[i] = (IW'(i) != idxA)
                       && (addr[i*AW +: AW] == addr[int'(idxA)*AW +: AW])
                       && (wren[int'(idxA)] || wren[i]);
            maskB[i]    = req[i] && foundA && (IW'(i) != idxA) && !conflict[i];
        end
    end

    rr_pick #(.NUM_REQ(NUM_REQ)) pickB (
        .mask  (maskB),
        .ptr   (ptr_q),
        .found (foundB),
        .idx   (idxB)
    );

    // A clash only counts as skipped if the search reached it before settling on B.
    always_comb begin
        int  j;
        logic passedB;
        skipFound = 1'b0;
        skipIdx   = '0;
        passedB   = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_q) + k) % NUM_REQ;
            if (foundB && (IW'(j) == idxB)) begin
                passedB = 1'b1;
            end
            if (!passedB && !skipFound && req[j] && conflict[j]) begin
                skipFound = 1'b1;
                skipIdx   = IW'(j);
            end
        end
    end

    always_comb begin
        logic [IW-1:0] lastWin;
        lastWin = foundB ? idxB : idxA;
        ptr_d   = ptr_q;
        if (foundA) begin
            if (skipFound) begin
                ptr_d = skipIdx;
            end else if (lastWin == IW'(NUM_REQ-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = lastWin + IW'(1);
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = !rst && ((foundA && idxA == IW'(i)) || (foundB && idxB == IW'(i)));
        end
        mem_address_0 = addr[int'(idxA)*AW +: AW];
        mem_data_0    = wdata[int'(idxA)*WIDTH +: WIDTH];
        mem_wren_0    = !rst && foundA && wren[int'(idxA)];
        mem_address_1 = addr[int'(idxB)*AW +: AW];
        mem_data_1    = wdata[int'(idxB)*WIDTH +: WIDTH];
        mem_wren_1    = !rst && foundB && wren[int'(idxB)];
    end

    always_comb begin
        tag0_d       = '0;
        tag1_d       = '0;
        tag0_d.valid = foundA && !wren[int'(idxA)];
        tag0_d.idx   = TAG_IDX_W'(idxA);
        tag1_d.valid = foundB && !wren[int'(idxB)];
        tag1_d.idx   = TAG_IDX_W'(idxB);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            ptr_q  <= '0;
            tag0_q <= '0;
            tag1_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            tag0_q <= tag0_d;
            tag1_q <= tag1_d;
        end
    end

    // Read data is masked while rst is high so an in-flight read never surfaces.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst && tag0_q.valid && tag0_q.idx == TAG_IDX_W'(i)) begin
                rvalid[i]               = 1'b1;
                rdata[i*WIDTH +: WIDTH] = mem_q_0;
            end else if (!rst && tag1_q.valid && tag1_q.idx == TAG_IDX_W'(i)) begin
                rvalid[i]               = 1'b1;
                rdata[i*WIDTH +: WIDTH] = mem_q_1;
            end
        end
    end

`ifdef MEM_DUAL_ARB_STATS_EN
    logic [CNT_W-1:0] grantCnt_q, skipCnt_q;
    logic [1:0]       grantInc;

    assign grantInc = {1'b0, foundA} + {1'b0, foundB};

    always_ff @(posedge clock) begin
        if (rst) begin
            grantCnt_q <= '0;
            skipCnt_q  <= '0;
        end else begin
            grantCnt_q <= satAdd(grantCnt_q, grantInc);
            skipCnt_q  <= satAdd(skipCnt_q, {1'b0, skipFound});
        end
    end

    assign grant_cnt = grantCnt_q;
    assign skip_cnt  = skipCnt_q;
`else
    // Arbitration only; no statistics state.
`endif

endmodule

// File: tb/tb_mem_dual_arb.sv
// Randomised and directed bench for mem_dual_arb with a behavioural dual-port RAM and
// a reference arbitration model; also covers MEM_DUAL_ARB_STATS_EN when defined.
module tb_mem_dual_arb;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int AW = 6;

    logic            clock = 1'b0;
    logic            rst   = 1'b1;
    logic [NR-1:0]   req   = '0;
    logic [NR-1:0]   wren  = '0;
    logic [NR*AW-1:0] addr = '0;
    logic [NR*W-1:0] wdata = '0;
    logic [NR-1:0]   gnt, rvalid;
    logic [NR*W-1:0] rdata;
    logic [AW-1:0]   mem_address_0, mem_address_1;
    logic [W-1:0]    mem_data_0, mem_data_1, mem_q_0, mem_q_1;
    logic            mem_wren_0, mem_wren_1;
`ifdef MEM_DUAL_ARB_STATS_EN
    logic [31:0]     grant_cnt, skip_cnt;
`endif

    mem_dual_arb #(.NUM_REQ(NR), .WIDTH(W), .DEPTH(64)) dut (
        .clock(clock), .rst(rst), .req(req), .wren(wren), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_address_0(mem_address_0), .mem_address_1(mem_address_1),
        .mem_data_0(mem_data_0), .mem_data_1(mem_data_1),
        .mem_wren_0(mem_wren_0), .mem_wren_1(mem_wren_1),
        .mem_q_0(mem_q_0), .mem_q_1(mem_q_1)
`ifdef MEM_DUAL_ARB_STATS_EN
        , .grant_cnt(grant_cnt), .skip_cnt(skip_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Behavioural dual-port RAM, reloaded with a known pattern while rst is high.
    logic [W-1:0] ram [64];
    always @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) ram[i] <= W'(i * 7 + 3);
        end else begin
            if (mem_wren_0) ram[mem_address_0] <= mem_data_0;
            if (mem_wren_1) ram[mem_address_1] <= mem_data_1;
        end
        mem_q_0 <= ram[mem_address_0];
        mem_q_1 <= ram[mem_address_1];
    end

    int testCnt = 0;
    int failCnt = 0;

    logic [AW-1:0] stimAddr [NR];
    logic [W-1:0]  stimData [NR];

    int           mPtr;
    logic [W-1:0] shadow [64];
    bit           expRvalid [NR];
    logic [W-1:0] expRdata [NR];
    longint       expGrantCnt, expSkipCnt;

    function automatic void arbModel(input logic [NR-1:0] r, input logic [NR-1:0] w,
                                     output int pa, output int pb, output int np,
                                     output bit skipped);
        int skipIdx;
        skipIdx = -1;
        pa = -1;
        pb = -1;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (mPtr + k) % NR;
            if (r[i]) begin
                if (pa < 0) pa = i;
                else if (pb < 0) begin
                    if (stimAddr[i] == stimAddr[pa] && (w[pa] || w[i])) begin
                        if (skipIdx < 0) skipIdx = i;
                    end else pb = i;
                end
            end
        end
        skipped = (skipIdx >= 0);
        if (pa < 0)       np = mPtr;
        else if (skipped) np = skipIdx;
        else              np = (((pb >= 0) ? pb : pa) + 1) % NR;
    endfunction

    task automatic checkOutput(input logic [NR-1:0] eg, input logic [NR-1:0] w,
                               input int pa, input int pb);
        testCnt++;
        assert (gnt === eg) else begin
            failCnt++; $error("FAIL gnt actual=%b required=%b", gnt, eg);
        end
        testCnt++;
        assert (mem_wren_0 === (pa >= 0 && w[pa])) else begin
            failCnt++; $error("FAIL mem_wren_0 actual=%b required=%b", mem_wren_0, (pa >= 0 && w[pa]));
        end
        testCnt++;
        assert (mem_wren_1 === (pb >= 0 && w[pb])) else begin
            failCnt++; $error("FAIL mem_wren_1 actual=%b required=%b", mem_wren_1, (pb >= 0 && w[pb]));
        end
        if (pa >= 0) begin
            testCnt++;
            assert (mem_address_0 === stimAddr[pa] && (!w[pa] || mem_data_0 === stimData[pa])) else begin
                failCnt++; $error("FAIL port0 addr/data actual=%0d/%h required=%0d/%h",
                                  mem_address_0, mem_data_0, stimAddr[pa], stimData[pa]);
            end
        end
        if (pb >= 0) begin
            testCnt++;
            assert (mem_address_1 === stimAddr[pb] && (!w[pb] || mem_data_1 === stimData[pb])) else begin
                failCnt++; $error("FAIL port1 addr/data actual=%0d/%h required=%0d/%h",
                                  mem_address_1, mem_data_1, stimAddr[pb], stimData[pb]);
            end
        end
        for (int i = 0; i < NR; i++) begin
            testCnt++;
            assert (rvalid[i] === expRvalid[i]) else begin
                failCnt++; $error("FAIL rvalid[%0d] actual=%b required=%b", i, rvalid[i], expRvalid[i]);
            end
            if (expRvalid[i]) begin
                testCnt++;
                assert (rdata[i*W +: W] === expRdata[i]) else begin
                    failCnt++; $error("FAIL rdata[%0d] actual=%h required=%h", i, rdata[i*W +: W], expRdata[i]);
                end
            end
        end
    endtask

    // One arbitration cycle: drive, check the combinational grant, clock, then advance the model.
    task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR-1:0] w);
        int pa, pb, np;
        bit skipped;
        logic [NR-1:0] eg;
        req  = r;
        wren = w;
        for (int i = 0; i < NR; i++) begin
            addr[i*AW +: AW] = stimAddr[i];
            wdata[i*W +: W]  = stimData[i];
        end
        arbModel(r, w, pa, pb, np, skipped);
        eg = '0;
        if (pa >= 0) eg[pa] = 1'b1;
        if (pb >= 0) eg[pb] = 1'b1;
        #1;
        checkOutput(eg, w, pa, pb);
        @(posedge clock);
        #1;
        for (int i = 0; i < NR; i++) expRvalid[i] = 1'b0;
        if (pa >= 0 && !w[pa]) begin expRvalid[pa] = 1'b1; expRdata[pa] = shadow[stimAddr[pa]]; end
        if (pb >= 0 && !w[pb]) begin expRvalid[pb] = 1'b1; expRdata[pb] = shadow[stimAddr[pb]]; end
        if (pa >= 0 && w[pa]) shadow[stimAddr[pa]] = stimData[pa];
        if (pb >= 0 && w[pb]) shadow[stimAddr[pb]] = stimData[pb];
        expGrantCnt += (pa >= 0) + (pb >= 0);
        expSkipCnt  += skipped;
        mPtr = np;
    endtask

    // Reset with every requester asking to write, so gating of gnt/wren/rvalid is visible.
    task automatic doReset();
        rst  = 1'b1;
        req  = '1;
        wren = '1;
        #1;
        testCnt++;
        assert (gnt === '0 && mem_wren_0 === 1'b0 && mem_wren_1 === 1'b0) else begin
            failCnt++; $error("FAIL reset_gate actual=%b/%b/%b required=0000/0/0", gnt, mem_wren_0, mem_wren_1);
        end
        testCnt++;
        assert (rvalid === '0) else begin
            failCnt++; $error("FAIL reset_rvalid actual=%b required=0000", rvalid);
        end
        @(posedge clock);
        #1;
        rst  = 1'b0;
        req  = '0;
        wren = '0;
        mPtr = 0;
        for (int i = 0; i < 64; i++) shadow[i] = W'(i * 7 + 3);
        for (int i = 0; i < NR; i++) expRvalid[i] = 1'b0;
        expGrantCnt = 0;
        expSkipCnt  = 0;
    endtask

    task automatic checkStats(input string tag);
`ifdef MEM_DUAL_ARB_STATS_EN
        testCnt++;
        assert (grant_cnt === 32'(expGrantCnt)) else begin
            failCnt++; $error("FAIL %s grant_cnt actual=%0d required=%0d", tag, grant_cnt, expGrantCnt);
        end
        testCnt++;
        assert (skip_cnt === 32'(expSkipCnt)) else begin
            failCnt++; $error("FAIL %s skip_cnt actual=%0d required=%0d", tag, skip_cnt, expSkipCnt);
        end
`else
        if (tag.len() == 0) $display("[TB] stats disabled");
`endif
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin stimAddr[i] = '0; stimData[i] = '0; end
        doReset();

        // Write then read back through requester 0.
        stimAddr[0] = 6'd5; stimData[0] = 8'hA5;
        applyStimulus(4'b0001, 4'b0001);
        applyStimulus(4'b0001, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);

        // All four reading distinct addresses for four cycles.
        doReset();
        for (int i = 0; i < NR; i++) stimAddr[i] = AW'(10 + i);
        repeat (4) applyStimulus(4'b1111, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);
        checkStats("all_reads");

        // Walk ptr to 3, then wrap-around grant of 3 and 0, then confirm ptr = 1.
        applyStimulus(4'b0100, 4'b0000);
        applyStimulus(4'b1001, 4'b0000);
        applyStimulus(4'b1111, 4'b0000);

        // Write/read clash on address 9 skips requester 1.
        doReset();
        stimAddr[0] = 6'd9; stimData[0] = 8'h3C;
        stimAddr[1] = 6'd9; stimAddr[2] = 6'd12;
        applyStimulus(4'b0111, 4'b0001);
        applyStimulus(4'b0010, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);
        checkStats("conflict");

        // Two reads of the same address, then two writes of the same address.
        stimAddr[0] = 6'd7; stimAddr[1] = 6'd7;
        applyStimulus(4'b0011, 4'b0000);
        stimAddr[0] = 6'd20; stimAddr[1] = 6'd20; stimAddr[2] = 6'd21;
        stimData[0] = 8'h11; stimData[1] = 8'h22;
        applyStimulus(4'b0111, 4'b0011);
        applyStimulus(4'b0000, 4'b0000);

        // Reset right after a read grant drops the read.
        stimAddr[0] = 6'd33;
        applyStimulus(4'b0001, 4'b0000);
        doReset();
        stimAddr[2] = 6'd40;
        applyStimulus(4'b0100, 4'b0000);

        // Random traffic over a small address range to provoke clashes.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                stimAddr[i] = AW'($urandom_range(0, 7));
                stimData[i] = W'($urandom);
            end
            if ($urandom_range(0, 59) == 0) doReset();
            else applyStimulus(NR'($urandom_range(0, 15)), NR'($urandom_range(0, 15)));
        end
        applyStimulus(4'b0000, 4'b0000);
        checkStats("random");

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
